seq_shift_unit: RTL and testbench



---
 rtl/seq_shift_unit_if.sv | 23 ++
 rtl/seq_shift_unit.sv | 106 ++++++++++
 tb/tb_seq_shift_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seq_shift_unit_if.sv
// rtl/seq_shift_unit_if.sv - start/busy/done handshake and operand/result bus for the serial shifter
interface seq_shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - one-bit-per-clock SLL/SRL/SRA shifter launched by start, finished by a done pulse
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_e             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_result;

  state_e             w_state_nxt;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [SHAMT_W-1:0] w_cnt_nxt;
  logic [1:0]         w_op_nxt;
  logic [WIDTH-1:0]   w_result_nxt;
  logic [WIDTH-1:0]   w_acc_step;
  logic               w_accepting;
  logic               w_load;

  // IDLE and DONE both accept a new launch, which is what makes back-to-back ops idle-free
  assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_load      = w_accepting && bus.start;

  always_comb begin
    w_acc_step = r_acc;
    case (r_op)
      OP_SLL:  w_acc_step = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_acc_step = {1'b0, r_acc[WIDTH-1:1]};
      OP_SRA:  w_acc_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_acc_step = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_load) begin
          w_acc_nxt   = bus.data_in;
          w_cnt_nxt   = (bus.op == OP_PASS) ? '0 : bus.shamt;
          w_op_nxt    = bus.op;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt != '0) begin
          w_acc_nxt = w_acc_step;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_result_nxt = r_acc;
          w_state_nxt  = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reset discards any in-flight operation outright, so no done pulse can follow it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign bus.busy   = (r_state == ST_SHIFT);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - directed bench for seq_shift_unit with hand-computed results and latencies
module tb_seq_shift_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = data;
    bus.shamt   = sh;
    step();
    bus.start   = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts edges until done is seen
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input logic [4:0] sh, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int bc;
    launch(op, data, sh);
    wait_done(lat, bc);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(bc), 32'(exp_lat));
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_res"}, bus.result, exp_res);
    step();
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"}, bus.result, exp_res);
  endtask

  initial begin
    int lat;
    int bc;
    int dcnt;
    int dat;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.data_in = 32'h0;
    bus.shamt   = 5'd0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res", bus.result, 32'h0);
    rst_n = 1'b1;
    step();

    run_op("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, 5);
    run_op("sra31", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 32);
    run_op("sra4", 2'b11, 32'h7FFF_FFF0, 5'd4, 32'h07FF_FFFF, 5);
    run_op("sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
    run_op("pass17", 2'b10, 32'hDEAD_BEEF, 5'd17, 32'hDEAD_BEEF, 1);

    // Starts and operand churn during SHIFT must be ignored
    launch(2'b01, 32'hF000_0000, 5'd8);
    dcnt = 0;
    dat  = 0;
    for (int i = 1; i <= 14; i++) begin
      bus.start   = (i == 2) || (i == 5);
      bus.data_in = 32'h1111_1111 * i;
      bus.op      = 2'(i);
      bus.shamt   = 5'(i + 3);
      step();
      if (i == 5) chk("ign_res_stable", bus.result, 32'hDEAD_BEEF);
      if (bus.done) begin
        dcnt++;
        dat = i;
      end
    end
    bus.start = 1'b0;
    chk("ign_done_cnt", 32'(dcnt), 32'd1);
    chk("ign_done_at", 32'(dat), 32'd9);
    chk("ign_res", bus.result, 32'h00F0_0000);

    // Start held high: second op is accepted in the DONE cycle of the first
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h1;
    bus.shamt   = 5'd1;
    step();
    wait_done(lat, bc);
    chk("b2b1_lat", 32'(lat), 32'd2);
    chk("b2b1_res", bus.result, 32'h2);
    bus.op      = 2'b01;
    bus.data_in = 32'h4;
    bus.shamt   = 5'd2;
    step();
    bus.start = 1'b0;
    chk("b2b_noidle_busy", 32'(bus.busy), 32'd1);
    chk("b2b_noidle_done", 32'(bus.done), 32'd0);
    chk("b2b_res_kept", bus.result, 32'h2);
    wait_done(lat, bc);
    chk("b2b2_lat", 32'(lat), 32'd3);
    chk("b2b2_res", bus.result, 32'h1);
    step();

    // Reset mid-operation discards it without a done pulse
    launch(2'b11, 32'hFFFF_0000, 5'd20);
    repeat (5) step();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_res", bus.result, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.done || bus.busy) dcnt++;
    end
    chk("post_rst_quiet", 32'(dcnt), 32'd0);
    run_op("sll2", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
